// File: rtl/mbssoc_irq_collector_if.sv
// Collector bus: raw/software requests, APIC acks, mask config in; masked pending vector
// and overrun status out.
interface mbssoc_irq_collector_if #(
    parameter int INT_SEL_WIDTH = 8,
    parameter int OVR_CNT_WIDTH = 8
);
    logic [INT_SEL_WIDTH-1:0] irq_raw;
    logic [INT_SEL_WIDTH-1:0] sw_set;
    logic [INT_SEL_WIDTH-1:0] int_ack;
    logic                     cfg_we;
    logic [INT_SEL_WIDTH-1:0] cfg_mask;
    logic                     ovr_clr;
    logic [INT_SEL_WIDTH-1:0] int_vec;
    logic                     irq_any;
    logic [INT_SEL_WIDTH-1:0] ovr_flag;
    logic [OVR_CNT_WIDTH-1:0] ovr_cnt;

    modport master (
        output irq_raw, sw_set, int_ack, cfg_we, cfg_mask, ovr_clr,
        input  int_vec, irq_any, ovr_flag, ovr_cnt
    );

    modport slave (
        input  irq_raw, sw_set, int_ack, cfg_we, cfg_mask, ovr_clr,
        output int_vec, irq_any, ovr_flag, ovr_cnt
    );
endinterface

// File: rtl/mbssoc_irq_collector.sv
// Interrupt front-end: synchronises device lines, keeps sticky pending bits per line,
// merges software sets, masks the result for the APIC and tracks lost edges.
module mbssoc_irq_collector #(
    parameter int                       INT_SEL_WIDTH = 8,
    parameter int                       SYNC_STAGES   = 2,
    parameter logic [INT_SEL_WIDTH-1:0] EDGE_MASK     = '1,
    parameter int                       OVR_CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mbssoc_irq_collector_if.slave bus
);
    localparam int W  = INT_SEL_WIDTH;
    localparam int HW = $clog2(W + 1);
    localparam int SW = ((OVR_CNT_WIDTH > HW) ? OVR_CNT_WIDTH : HW) + 1;
    localparam logic [SW-1:0] CNT_MAX = SW'({OVR_CNT_WIDTH{1'b1}});

    logic [SYNC_STAGES-1:0][W-1:0] r_sync;
    logic [W-1:0]             r_s_prev;
    logic [W-1:0]             r_pend;
    logic [W-1:0]             r_mask;
    logic [W-1:0]             r_int_vec;
    logic                     r_irq_any;
    logic [W-1:0]             r_ovr_flag;
    logic [OVR_CNT_WIDTH-1:0] r_ovr_cnt;

    logic [W-1:0]             w_s;
    logic [W-1:0]             w_edge_set;
    logic [W-1:0]             w_set;
    logic [W-1:0]             w_pend_nxt;
    logic [W-1:0]             w_mask_nxt;
    logic [W-1:0]             w_vec_nxt;
    logic [W-1:0]             w_ovr_hit;
    logic [HW-1:0]            w_hits;
    logic [SW-1:0]            w_sum;
    logic [OVR_CNT_WIDTH-1:0] w_cnt_nxt;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_edge_set = w_s & ~r_s_prev & EDGE_MASK;
    assign w_set      = w_edge_set | (w_s & ~EDGE_MASK) | bus.sw_set;
    // Set wins over a same-cycle ack, so a request landing on its own retire is never lost.
    assign w_pend_nxt = (r_pend & ~bus.int_ack) | w_set;
    assign w_mask_nxt = bus.cfg_we ? bus.cfg_mask : r_mask;
    assign w_vec_nxt  = w_pend_nxt & w_mask_nxt;

    // Level sources re-assert by design, so only edges and software sets can be lost.
    assign w_ovr_hit  = (w_edge_set | bus.sw_set) & r_pend & ~bus.int_ack;

    always_comb begin
        w_hits = '0;
        for (int i = 0; i < W; i++) begin
            w_hits = w_hits + HW'(w_ovr_hit[i]);
        end
    end

    assign w_sum     = SW'(r_ovr_cnt) + SW'(w_hits);
    assign w_cnt_nxt = (w_sum > CNT_MAX) ? OVR_CNT_WIDTH'(CNT_MAX) : OVR_CNT_WIDTH'(w_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync     <= '0;
            r_s_prev   <= '0;
            r_pend     <= '0;
            r_mask     <= '1;
            r_int_vec  <= '0;
            r_irq_any  <= 1'b0;
            r_ovr_flag <= '0;
            r_ovr_cnt  <= '0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], bus.irq_raw};
            r_s_prev  <= w_s;
            r_pend    <= w_pend_nxt;
            r_mask    <= w_mask_nxt;
            r_int_vec <= w_vec_nxt;
            r_irq_any <= |w_vec_nxt;
            if (bus.ovr_clr) begin
                r_ovr_flag <= '0;
                r_ovr_cnt  <= '0;
            end else begin
                r_ovr_flag <= r_ovr_flag | w_ovr_hit;
                r_ovr_cnt  <= w_cnt_nxt;
            end
        end
    end

    assign bus.int_vec  = r_int_vec;
    assign bus.irq_any  = r_irq_any;
    assign bus.ovr_flag = r_ovr_flag;
    assign bus.ovr_cnt  = r_ovr_cnt;
endmodule
